sevenseg_scan_controller: RTL

Time-multiplexed scan controller for a bank of common-anode seven-segment digits sharing one hex-to-segment decoder. Holds a shadow copy of the displayed value, cycles the active digit at a fixed refresh rate, drives the active-low anode strobes and registered segment lines, and applies per-digit blinking. Sits between the lab's value-producing logic and the board display pins. Accepts new values only at frame boundaries, so a frame never shows a mix of old and new digits.

---
 rtl/sevenseg_scan_controller_pkg.sv | 23 ++
 rtl/sevenseg_scan_controller_hexdec.sv | 36 +++
 rtl/sevenseg_scan_controller.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/sevenseg_scan_controller_pkg.sv
// Shared constants and helpers for the seven-segment scan controller.
// Holds the blank segment pattern, default timing divisors and the
// index-to-anode helper used by the scan logic.
package sevenseg_scan_controller_pkg;

    // Segment vectors are written a..g from MSB to LSB, active low.
    localparam logic [6:0] SEG_BLANK = 7'b111_1111;

    localparam int DEFAULT_REFRESH_DIV = 100000;
    localparam int DEFAULT_BLINK_DIV   = 50000000;

    localparam int MAX_DIGITS = 8;

    // One-hot-low anode pattern for digit idx; unused high bits stay 1.
    function automatic logic [MAX_DIGITS-1:0] an_onehot_low(
        input logic [2:0] idx
    );
        logic [MAX_DIGITS-1:0] one;
        one = {{(MAX_DIGITS-1){1'b0}}, 1'b1};
        return ~(one << idx);
    endfunction

endpackage

// File: rtl/sevenseg_scan_controller_hexdec.sv
// sevenseghexdecoder: combinational hex nibble to seven-segment decoder.
// Ports: hex (nibble in), flash (1 = force blank), seg (a..g MSB..LSB,
// active low). Pure combinational; the caller registers the output.
module sevenseghexdecoder
    import sevenseg_scan_controller_pkg::*;
(
    input  logic [3:0] hex,
    input  logic       flash,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        if (!flash) begin
            unique case (hex)
                4'h0: seg = 7'b000_0001;
                4'h1: seg = 7'b100_1111;
                4'h2: seg = 7'b001_0010;
                4'h3: seg = 7'b000_0110;
                4'h4: seg = 7'b100_1100;
                4'h5: seg = 7'b010_0100;
                4'h6: seg = 7'b010_0000;
                4'h7: seg = 7'b000_1111;
                4'h8: seg = 7'b000_0000;
                4'h9: seg = 7'b000_0100;
                4'hA: seg = 7'b000_1000;
                4'hB: seg = 7'b110_0000;
                4'hC: seg = 7'b011_0001;
                4'hD: seg = 7'b100_0010;
                4'hE: seg = 7'b011_0000;
                4'hF: seg = 7'b011_1000;
            endcase
        end
    end

endmodule

// File: rtl/sevenseg_scan_controller.sv
// Time-multiplexed scan controller for common-anode seven-segment digits.
// Ports: clk, reset (async, active high), value_in/load_valid/load_ready
// (frame-boundary load handshake), blink_en/blink_mask (per-digit blink),
// an (active-low anodes), seg (a..g MSB..LSB, active low), digit_idx.
// Optional macro SEVENSEG_BLANK_LEADING_ZERO_EN blanks leading zero digits.
module sevenseg_scan_controller
    import sevenseg_scan_controller_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = DEFAULT_REFRESH_DIV,
    parameter int BLINK_DIV   = DEFAULT_BLINK_DIV,
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
)(
    input  logic                    clk,
    input  logic                    reset,
    input  logic [4*NUM_DIGITS-1:0] value_in,
    input  logic                    load_valid,
    output logic                    load_ready,
    input  logic                    blink_en,
    input  logic [NUM_DIGITS-1:0]   blink_mask,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [6:0]              seg,
    output logic [IDX_W-1:0]        digit_idx
);

    localparam int PRE_W = $clog2(REFRESH_DIV);
    localparam int BL_W  = $clog2(BLINK_DIV);

    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(REFRESH_DIV - 1);
    localparam logic [BL_W-1:0]  BL_LAST  = BL_W'(BLINK_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    typedef logic [NUM_DIGITS-1:0] an_vec_t;

    logic [PRE_W-1:0]        presc_q, presc_d;
    logic [BL_W-1:0]         blink_cnt_q, blink_cnt_d;
    logic                    blink_phase_q, blink_phase_d;
    logic                    active_q, active_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0] shadow_q, shadow_d;
    an_vec_t                 an_q, an_d;
    logic [6:0]              seg_q, seg_d;

    logic                    tick;
    logic                    frame_end;
    logic                    blink_wrap;
    logic [IDX_W-1:0]        idx_next;
    logic [3:0]              nib_sel;
    logic                    mask_sel;
    logic                    lz_sel;
    logic [NUM_DIGITS-1:0]   lz_vec;
    logic                    blank;
    an_vec_t                 an_sel;
    logic [6:0]              dec_seg;

    // Refresh prescaler and digit-slot tick.
    always_comb begin
        tick    = (presc_q == PRE_LAST);
        presc_d = tick ? '0 : presc_q + 1'b1;
    end

    // Free-running blink timer, independent of the refresh prescaler.
    always_comb begin
        blink_wrap    = (blink_cnt_q == BL_LAST);
        blink_cnt_d   = blink_wrap ? '0 : blink_cnt_q + 1'b1;
        blink_phase_d = blink_phase_q ^ blink_wrap;
    end

    // The first tick after reset lights digit 0 instead of advancing,
    // so digit 0 comes up one full slot after reset release.
    always_comb begin
        active_d = active_q | tick;
        if (!active_q || idx_q == IDX_LAST) begin
            idx_next = '0;
        end else begin
            idx_next = idx_q + 1'b1;
        end
        idx_d = tick ? idx_next : idx_q;
    end

    // Shadow only changes at a frame boundary, so a frame never mixes
    // old and new digits.
    always_comb begin
        frame_end = tick & (idx_q == IDX_LAST);
        shadow_d  = (load_valid & frame_end) ? value_in : shadow_q;
    end

    // Leading-zero map built from the value being shown on this edge.
`ifdef SEVENSEG_BLANK_LEADING_ZERO_EN
    logic hi_zero;
    always_comb begin
        hi_zero = 1'b1;
        lz_vec  = '0;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            hi_zero   = hi_zero & (shadow_d[i*4 +: 4] == 4'h0);
            lz_vec[i] = hi_zero;
        end
    end
`else
    always_comb begin
        lz_vec = '0;
    end
`endif

    // Per-digit selection for the slot about to be driven.
    always_comb begin
        nib_sel  = '0;
        mask_sel = 1'b0;
        lz_sel   = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_next == IDX_W'(i)) begin
                nib_sel  = shadow_d[i*4 +: 4];
                mask_sel = blink_mask[i];
                lz_sel   = lz_vec[i];
            end
        end
    end

    sevenseghexdecoder u_dec (
        .hex   (nib_sel),
        .flash (1'b0),
        .seg   (dec_seg)
    );

    // Anode and segment registers load only on tick; blink phase is the
    // registered one so a toggle never lands mid-slot.
    always_comb begin
        blank  = (blink_en & mask_sel & blink_phase_q) | lz_sel;
        an_sel = an_vec_t'(an_onehot_low(3'(idx_next)));
        an_d   = an_q;
        seg_d  = seg_q;
        if (tick) begin
            an_d  = blank ? '1 : an_sel;
            seg_d = dec_seg;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc_q       <= '0;
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
            active_q      <= 1'b0;
            idx_q         <= '0;
            shadow_q      <= '0;
            an_q          <= '1;
            seg_q         <= SEG_BLANK;
        end else begin
            presc_q       <= presc_d;
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
            active_q      <= active_d;
            idx_q         <= idx_d;
            shadow_q      <= shadow_d;
            an_q          <= an_d;
            seg_q         <= seg_d;
        end
    end

    assign load_ready = frame_end;
    assign an         = an_q;
    assign seg        = seg_q;
    assign digit_idx  = idx_q;

endmodule
